uart_packet_router: RTL and testbench

Parametrised byte-stream demultiplexer between the UART receiver and the per-channel loaders (weights, image, future channels). It frames packets by per-channel two-byte start markers, forwards exactly the declared payload length, and validates a trailing checksum and mirrored end markers. It also adds inter-byte timeout recovery and per-channel enables, and passes unframed bytes through as commands.

---
 rtl/uart_packet_router.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_packet_router.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_packet_router.sv
// rtl/uart_packet_router.sv - framed byte-stream demultiplexer with command passthrough
//
// Splits the UART receive byte stream into per-channel packets framed as
// S1 S2 <LEN payload bytes> CSUM S2 S1, and forwards unframed IDLE bytes
// as commands.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   in_data/in_valid   received byte and its one-cycle strobe
//   ch_enable          per-channel permission to start a packet (sampled in IDLE)
//   cmd_enable         forward unframed IDLE bytes as commands
//   out_data/out_valid payload byte, one-hot owning-channel strobe
//   out_last           marks the final payload byte
//   cmd_data/cmd_valid command byte and strobe
//   pkt_done           per-channel pulse: packet closed with good checksum and end markers
//   pkt_err/err_code   abort pulse; code 1 checksum, 2 end marker, 3 timeout (held)
//   busy               a packet is in progress
module uart_packet_router #(
  parameter int                       NUM_CH     = 2,
  parameter int                       LEN_W      = 16,
  parameter logic [8*NUM_CH-1:0]      START1_VEC = 16'hBBAA,
  parameter logic [8*NUM_CH-1:0]      START2_VEC = 16'h6655,
  parameter logic [NUM_CH*LEN_W-1:0]  LEN_VEC    = 32'h0310_32B8,
  parameter int                       TIMEOUT    = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  input  logic [NUM_CH-1:0] ch_enable,
  input  logic              cmd_enable,
  output logic [7:0]        out_data,
  output logic [NUM_CH-1:0] out_valid,
  output logic              out_last,
  output logic [7:0]        cmd_data,
  output logic              cmd_valid,
  output logic [NUM_CH-1:0] pkt_done,
  output logic              pkt_err,
  output logic [1:0]        err_code,
  output logic              busy
);

  localparam int          CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  // Idle-cycle count at which an in-packet stall is declared dead.
  localparam logic [31:0] TO_LAST = 32'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_HDR2, S_PAYLOAD, S_CSUM, S_END1, S_END2} state_t;

  logic [7:0]       s1  [NUM_CH];
  logic [7:0]       s2  [NUM_CH];
  logic [LEN_W-1:0] len [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign s1[g]  = START1_VEC[8*g +: 8];
    assign s2[g]  = START2_VEC[8*g +: 8];
    assign len[g] = LEN_VEC[LEN_W*g +: LEN_W];
  end

  state_t            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        sum_q, sum_d;
  logic              csum_bad_q, csum_bad_d;
  logic              end_bad_q, end_bad_d;
  logic [31:0]       timer_q, timer_d;
  logic [7:0]        out_data_q, out_data_d;
  logic [NUM_CH-1:0] out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [7:0]        cmd_data_q, cmd_data_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [NUM_CH-1:0] pkt_done_q, pkt_done_d;
  logic              pkt_err_q, pkt_err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              busy_q, busy_d;

  logic              hit;
  logic [CH_W-1:0]   hit_ch;
  logic [NUM_CH-1:0] ch_oh;

  // Descending scan so the lowest enabled matching channel wins.
  always_comb begin
    hit    = 1'b0;
    hit_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_enable[i] && (in_data == s1[i])) begin
        hit    = 1'b1;
        hit_ch = CH_W'(i);
      end
    end
  end

  assign ch_oh = NUM_CH'(1) << ch_q;

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    csum_bad_d  = csum_bad_q;
    end_bad_d   = end_bad_q;
    timer_d     = timer_q;
    out_data_d  = out_data_q;
    out_valid_d = '0;
    out_last_d  = 1'b0;
    cmd_data_d  = cmd_data_q;
    cmd_valid_d = 1'b0;
    pkt_done_d  = '0;
    pkt_err_d   = 1'b0;
    err_code_d  = err_code_q;
    if (in_valid) begin
      // A byte arriving on the timeout cycle wins over the timeout.
      timer_d = '0;
      unique case (state_q)
        S_IDLE: begin
          if (hit) begin
            ch_d    = hit_ch;
            state_d = S_HDR2;
          end else if (cmd_enable) begin
            cmd_data_d  = in_data;
            cmd_valid_d = 1'b1;
          end
        end
        S_HDR2: begin
          // A wrong second marker is dropped, not re-examined as a new START1.
          if (in_data == s2[ch_q]) begin
            state_d = S_PAYLOAD;
            cnt_d   = '0;
            sum_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_PAYLOAD: begin
          out_data_d  = in_data;
          out_valid_d = ch_oh;
          sum_d       = sum_q + in_data;
          cnt_d       = cnt_q + LEN_W'(1);
          if (cnt_q == len[ch_q] - LEN_W'(1)) begin
            out_last_d = 1'b1;
            state_d    = S_CSUM;
          end
        end
        S_CSUM: begin
          csum_bad_d = (in_data != sum_q);
          state_d    = S_END1;
        end
        S_END1: begin
          end_bad_d = (in_data != s2[ch_q]);
          state_d   = S_END2;
        end
        S_END2: begin
          if (csum_bad_q) begin
            pkt_err_d  = 1'b1;
            err_code_d = 2'd1;
          end else if (end_bad_q || (in_data != s1[ch_q])) begin
            pkt_err_d  = 1'b1;
            err_code_d = 2'd2;
          end else begin
            pkt_done_d = ch_oh;
          end
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if ((TIMEOUT != 0) && (state_q != S_IDLE)) begin
      if (timer_q == TO_LAST) begin
        pkt_err_d  = 1'b1;
        err_code_d = 2'd3;
        state_d    = S_IDLE;
      end else begin
        timer_d = timer_q + 32'd1;
      end
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ch_q        <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      csum_bad_q  <= 1'b0;
      end_bad_q   <= 1'b0;
      timer_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= '0;
      out_last_q  <= 1'b0;
      cmd_data_q  <= '0;
      cmd_valid_q <= 1'b0;
      pkt_done_q  <= '0;
      pkt_err_q   <= 1'b0;
      err_code_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      csum_bad_q  <= csum_bad_d;
      end_bad_q   <= end_bad_d;
      timer_q     <= timer_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      cmd_data_q  <= cmd_data_d;
      cmd_valid_q <= cmd_valid_d;
      pkt_done_q  <= pkt_done_d;
      pkt_err_q   <= pkt_err_d;
      err_code_q  <= err_code_d;
      busy_q      <= busy_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign cmd_data  = cmd_data_q;
  assign cmd_valid = cmd_valid_q;
  assign pkt_done  = pkt_done_q;
  assign pkt_err   = pkt_err_q;
  assign err_code  = err_code_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_packet_router.sv
// tb/tb_uart_packet_router.sv - self-checking bench for uart_packet_router
module tb_uart_packet_router;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic [1:0] ch_enable = 2'b11;
  logic       cmd_enable = 1'b0;
  logic [7:0] out_data;
  logic [1:0] out_valid;
  logic       out_last;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic [1:0] pkt_done;
  logic       pkt_err;
  logic [1:0] err_code;
  logic       busy;

  always #5 clk = ~clk;

  uart_packet_router #(.TIMEOUT(100)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .ch_enable(ch_enable), .cmd_enable(cmd_enable),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid),
    .pkt_done(pkt_done), .pkt_err(pkt_err), .err_code(err_code), .busy(busy)
  );

  // Framing constants of the default configuration.
  logic [7:0] S1 [2] = '{8'hAA, 8'hBB};
  logic [7:0] S2 [2] = '{8'h55, 8'h66};
  int         LENS [2] = '{12984, 784};

  typedef struct { int ch; logic [7:0] data; logic last; } pay_t;
  typedef struct { logic [1:0] done; logic err; logic [1:0] code; } end_t;
  typedef struct {
    int ch; logic [7:0] csum_add; logic [7:0] e1_xor; logic [7:0] e2_xor; logic [1:0] exp_code;
  } vec_t;

  pay_t       exp_pay [$];
  logic [7:0] exp_cmd [$];
  end_t       exp_end [$];
  logic [1:0] last_code = 2'd0;
  int         checks = 0;
  int         errors = 0;
  bit         started = 1'b0;

  function automatic logic [1:0] oh(input int ch);
    return 2'(1) << ch;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every output strobe must match the next expected event.
  always @(negedge clk) begin : mon
    pay_t p;
    end_t e;
    if (started && !rst) begin
      if (out_valid != 2'b00) begin
        if (exp_pay.size() == 0) chk("unexpected_payload", {24'd0, out_data}, 32'hFFFF_FFFF);
        else begin
          p = exp_pay.pop_front();
          chk("out_valid", {30'd0, out_valid}, {30'd0, oh(p.ch)});
          chk("out_data", {24'd0, out_data}, {24'd0, p.data});
          chk("out_last", {31'd0, out_last}, {31'd0, p.last});
        end
      end else if (out_last) chk("out_last_without_valid", {31'd0, out_last}, 32'd0);
      if (cmd_valid) begin
        if (exp_cmd.size() == 0) chk("unexpected_cmd", {24'd0, cmd_data}, 32'hFFFF_FFFF);
        else chk("cmd_data", {24'd0, cmd_data}, {24'd0, exp_cmd.pop_front()});
      end
      if (pkt_done != 2'b00 || pkt_err) begin
        if (exp_end.size() == 0) chk("unexpected_end", {29'd0, pkt_err, pkt_done}, 32'hFFFF_FFFF);
        else begin
          e = exp_end.pop_front();
          chk("pkt_done", {30'd0, pkt_done}, {30'd0, e.done});
          chk("pkt_err", {31'd0, pkt_err}, {31'd0, e.err});
          chk("err_code", {30'd0, err_code}, {30'd0, e.code});
        end
      end
    end
  end

  task automatic put(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Frame-level model: payload is forwarded verbatim, sum mod 256 decides CSUM,
  // and the outcome of the closing bytes is given by the caller's exp code.
  task automatic send_frame(input int ch, input bit rnd, input logic [7:0] csum_add,
                            input logic [7:0] e1_xor, input logic [7:0] e2_xor,
                            input logic [1:0] code, input int gap_max,
                            input int stall_at, input int stall_len);
    logic [7:0] b;
    logic [7:0] sum;
    sum = 8'h00;
    put(S1[ch]);
    put(S2[ch]);
    for (int i = 0; i < LENS[ch]; i++) begin
      b = rnd ? 8'($urandom) : 8'(i);
      sum = sum + b;
      exp_pay.push_back('{ch, b, (i == LENS[ch] - 1)});
      if (gap_max > 0) idle($urandom_range(0, gap_max));
      if (i == stall_at) idle(stall_len);
      put(b);
    end
    put(sum + csum_add);
    put(S2[ch] ^ e1_xor);
    put(S1[ch] ^ e2_xor);
    if (code == 2'd0) exp_end.push_back('{oh(ch), 1'b0, last_code});
    else begin
      exp_end.push_back('{2'b00, 1'b1, code});
      last_code = code;
    end
  endtask

  task automatic drain(input string tag);
    idle(3);
    chk({tag, "_pay_drained"}, exp_pay.size(), 0);
    chk({tag, "_cmd_drained"}, exp_cmd.size(), 0);
    chk({tag, "_end_drained"}, exp_end.size(), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out_data"}, {24'd0, out_data}, 0);
    chk({tag, "_out_valid"}, {30'd0, out_valid}, 0);
    chk({tag, "_out_last"}, {31'd0, out_last}, 0);
    chk({tag, "_cmd_data"}, {24'd0, cmd_data}, 0);
    chk({tag, "_cmd_valid"}, {31'd0, cmd_valid}, 0);
    chk({tag, "_pkt_done"}, {30'd0, pkt_done}, 0);
    chk({tag, "_pkt_err"}, {31'd0, pkt_err}, 0);
    chk({tag, "_err_code"}, {30'd0, err_code}, 0);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    vec_t       vecs [7];
    int         k;
    int         sel;
    logic [7:0] b;
    logic [7:0] ca, x1, x2;
    logic [1:0] code;

    vecs[0] = '{1, 8'h00, 8'h00, 8'h00, 2'd0};  // good ch1
    vecs[1] = '{1, 8'h01, 8'h00, 8'h00, 2'd1};  // CSUM+1
    vecs[2] = '{1, 8'h00, 8'h00, 8'hBB, 2'd2};  // E2 = 00
    vecs[3] = '{1, 8'h00, 8'h00, 8'h00, 2'd0};  // good frame right after an error
    vecs[4] = '{1, 8'h00, 8'h01, 8'h00, 2'd2};  // bad E1
    vecs[5] = '{1, 8'h80, 8'h00, 8'h01, 2'd1};  // checksum outranks end marker
    vecs[6] = '{0, 8'h00, 8'h00, 8'h00, 2'd0};  // good ch0, long length

    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    started = 1'b1;
    idle(2);

    // Table frames, back to back; cmd_enable is on so stray commands would show.
    cmd_enable = 1'b1;
    for (int r = 0; r < 7; r++) begin
      send_frame(vecs[r].ch, 1'b0, vecs[r].csum_add, vecs[r].e1_xor, vecs[r].e2_xor,
                 vecs[r].exp_code, 0, -1, 0);
    end
    drain("table");

    // Timeout after the 10th payload byte.
    cmd_enable = 1'b0;
    put(8'hBB);
    chk("busy_after_s1", {31'd0, busy}, 1);
    put(8'h66);
    for (int i = 0; i < 10; i++) begin
      exp_pay.push_back('{1, 8'(i + 1), 1'b0});
      put(8'(i + 1));
    end
    exp_end.push_back('{2'b00, 1'b1, 2'd3});
    last_code = 2'd3;
    k = 0;
    for (int c = 1; c <= 150; c++) begin
      @(posedge clk); #1;
      if (pkt_err) begin k = c; break; end
    end
    chk("timeout_cycle", k, 100);
    chk("timeout_busy", {31'd0, busy}, 0);
    chk("timeout_err_code", {30'd0, err_code}, 3);
    cmd_enable = 1'b1;
    exp_cmd.push_back(8'hCC);
    put(8'hCC);
    chk("cmd_after_timeout_valid", {31'd0, cmd_valid}, 1);
    chk("cmd_after_timeout_data", {24'd0, cmd_data}, 32'hCC);

    // A byte landing exactly on the timeout cycle keeps the packet alive.
    send_frame(1, 1'b0, 8'h00, 8'h00, 8'h00, 2'd0, 0, 5, 99);
    idle(2);
    chk("err_code_held_after_done", {30'd0, err_code}, 3);
    drain("timeout");

    // Disabled channel: its markers become plain commands.
    ch_enable = 2'b10;
    exp_cmd.push_back(8'hAA);
    put(8'hAA);
    chk("disabled_busy_aa", {31'd0, busy}, 0);
    exp_cmd.push_back(8'h55);
    put(8'h55);
    chk("disabled_busy_55", {31'd0, busy}, 0);
    cmd_enable = 1'b0;
    put(8'h12);
    ch_enable = 2'b11;
    drain("disabled");

    // Ch0 payload full of marker values, then reset mid-payload.
    put(8'hAA);
    put(8'h55);
    chk("ch0_busy", {31'd0, busy}, 1);
    for (int i = 0; i < 40; i++) begin
      sel = i % 4;
      b = (sel == 0) ? 8'h55 : (sel == 1) ? 8'hAA : (sel == 2) ? 8'hBB : 8'h66;
      exp_pay.push_back('{0, b, 1'b0});
      put(b);
    end
    chk("ch0_busy_mid", {31'd0, busy}, 1);
    idle(1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_all_zero("midreset");
    rst = 1'b0;
    last_code = 2'd0;
    idle(5);
    send_frame(1, 1'b0, 8'h00, 8'h00, 8'h00, 2'd0, 0, -1, 0);
    drain("after_reset");

    // Randomized traffic: commands, aborted headers and corrupted frames.
    for (int f = 0; f < 6; f++) begin
      cmd_enable = 1'($urandom_range(0, 1));
      for (int n = $urandom_range(0, 3); n > 0; n--) begin
        do b = 8'($urandom); while (b == 8'hAA || b == 8'hBB);
        if (cmd_enable) exp_cmd.push_back(b);
        put(b);
      end
      if ($urandom_range(0, 1) == 1) begin
        put(8'hBB);
        put(($urandom_range(0, 1) == 1) ? 8'hBB : 8'hAA);
      end
      sel = $urandom_range(0, 3);
      ca = (sel == 1) ? 8'($urandom_range(1, 255)) : 8'h00;
      x1 = (sel == 2) ? 8'($urandom_range(1, 255)) : 8'h00;
      x2 = (sel == 3) ? 8'($urandom_range(1, 255)) : 8'h00;
      code = (ca != 8'h00) ? 2'd1 : ((x1 | x2) != 8'h00) ? 2'd2 : 2'd0;
      send_frame(1, 1'b1, ca, x1, x2, code, $urandom_range(0, 2), -1, 0);
    end
    drain("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
